read_mem: RTL

Readout side of the analyzer's circular capture buffer. After capture stops, it walks the buffer from oldest to newest sample and streams each word out over a valid/ready interface, for example to the UART/host link. It uses the writer's final write address and primed flag to find the oldest sample and the sample count. It drives the buffer's synchronous read port and asserts busy so top level can gate the writer's write_enable during readout.

---
 rtl/read_mem_pkg.sv | 9 +
 rtl/read_mem.sv | 105 ++++++++++
 2 files changed

// File: rtl/read_mem_pkg.sv
// Shared sizing for the capture-buffer readout path.
// Mirrors the analyzer-wide DATA_WIDTH / ADDR_WIDTH / MEMORY_SIZE constants.
package read_mem_pkg;

    localparam int RM_DATA_WIDTH  = 8;
    localparam int RM_ADDR_WIDTH  = 4;
    localparam int RM_MEMORY_SIZE = 1 << RM_ADDR_WIDTH;

endpackage

// File: rtl/read_mem.sv
// Readout of the circular capture buffer, oldest to newest sample.
// Drives the buffer's synchronous read port and streams words over valid/ready.
module read_mem
    import read_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = RM_DATA_WIDTH,
    parameter int ADDR_WIDTH  = RM_ADDR_WIDTH,
    parameter int MEMORY_SIZE = RM_MEMORY_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_e;

    // Sample count needs one extra bit so a full primed buffer is representable.
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(MEMORY_SIZE);
    localparam logic [ADDR_WIDTH:0] ONE_LEFT   = (ADDR_WIDTH+1)'(1);

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] raddr_q,     raddr_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        remaining_d = remaining_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    raddr_d     = primed ? waddr : '0;
                    remaining_d = primed ? FULL_COUNT : {1'b0, waddr};
                    state_d     = (!primed && (waddr == '0)) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                out_data_d  = rdata;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                // Address advance wraps naturally at the buffer end.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - ONE_LEFT;
                    raddr_d     = raddr_q + ADDR_WIDTH'(1);
                    state_d     = (remaining_q == ONE_LEFT) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            raddr_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            remaining_q <= remaining_d;
        end
    end

    assign raddr     = raddr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
